// File: rtl/board_ui_pkg.sv
// Shared types and cycle-count helpers for the front-panel controller.
package board_ui_pkg;

  typedef enum logic [1:0] {
    LED_OFF  = 2'd0,
    LED_ON   = 2'd1,
    LED_SLOW = 2'd2,
    LED_FAST = 2'd3
  } led_mode_t;

  typedef enum logic [1:0] {
    B_IDLE = 2'd0,
    B_ON   = 2'd1,
    B_OFF  = 2'd2
  } beep_state_t;

  function automatic int ms_cycles(int clk_hz, int ms);
    return (clk_hz / 1000) * ms;
  endfunction

  // Width of a counter that runs 0..n-1; never narrower than one bit.
  function automatic int cnt_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/board_ui_ctrl_btn_debounce.sv
// One active-low button: 2-flop synchronizer, stability counter and press/release pulses.
module btn_debounce
  import board_ui_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel
);

  localparam int DB_CYC = ms_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int CW     = cnt_width(DB_CYC);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYC - 1);

  logic [1:0]    sync;
  logic          stable;
  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync   <= 2'b11;
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
      rel    <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      press <= 1'b0;
      rel   <= 1'b0;
      if (sync[1] == stable) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        stable <= sync[1];
        cnt    <= '0;
        press  <= ~sync[1];
        rel    <= sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign level = ~stable;

endmodule

// File: rtl/board_ui_ctrl.sv
// Front-panel controller: debounced buttons, per-LED blink modes and a burst-sequenced beeper.
module board_ui_ctrl
  import board_ui_pkg::*;
#(
  parameter int CLK_HZ        = 50_000_000,
  parameter int N_LED         = 6,
  parameter int N_BTN         = 2,
  parameter int DEBOUNCE_MS   = 20,
  parameter int BLINK_SLOW_MS = 500,
  parameter int BLINK_FAST_MS = 125,
  parameter int BEEP_HZ       = 2000,
  parameter int BEEP_ON_MS    = 100,
  parameter int BEEP_OFF_MS   = 100
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_BTN-1:0]         btn_raw,
  output logic [N_BTN-1:0]         btn_level,
  output logic [N_BTN-1:0]         btn_press,
  output logic [N_BTN-1:0]         btn_release,
  input  logic                     led_we,
  input  logic [$clog2(N_LED)-1:0] led_idx,
  input  logic [1:0]               led_mode,
  output logic [N_LED-1:0]         leds,
  input  logic                     beep_start,
  input  logic [3:0]               beep_count,
  output logic                     beep_busy,
  output logic                     beep_out
);

  if (CLK_HZ % 1000 != 0) begin : g_bad_clk
    $error("CLK_HZ must be a multiple of 1000");
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    btn_debounce #(
      .CLK_HZ      (CLK_HZ),
      .DEBOUNCE_MS (DEBOUNCE_MS)
    ) u_db (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_raw[g]),
      .level (btn_level[g]),
      .press (btn_press[g]),
      .rel   (btn_release[g])
    );
  end

  // ---------------- LEDs ----------------
  localparam int SLOW_CYC = ms_cycles(CLK_HZ, BLINK_SLOW_MS);
  localparam int FAST_CYC = ms_cycles(CLK_HZ, BLINK_FAST_MS);
  localparam int SW = cnt_width(SLOW_CYC);
  localparam int FW = cnt_width(FAST_CYC);

  led_mode_t     modes [N_LED];
  logic [SW-1:0] slow_cnt;
  logic [FW-1:0] fast_cnt;
  logic          slow_ph, fast_ph;
  logic          idx_ok;

  assign idx_ok = (int'(led_idx) < N_LED);

  // NOTE: the mode table is a handful of flops, so it is reset explicitly rather than left as RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_LED; i++) modes[i] <= LED_OFF;
      slow_cnt <= '0;
      fast_cnt <= '0;
      slow_ph  <= 1'b0;
      fast_ph  <= 1'b0;
    end else begin
      if (led_we && idx_ok) modes[led_idx] <= led_mode_t'(led_mode);
      if (slow_cnt == SW'(SLOW_CYC - 1)) begin
        slow_cnt <= '0;
        slow_ph  <= ~slow_ph;
      end else begin
        slow_cnt <= slow_cnt + 1'b1;
      end
      if (fast_cnt == FW'(FAST_CYC - 1)) begin
        fast_cnt <= '0;
        fast_ph  <= ~fast_ph;
      end else begin
        fast_cnt <= fast_cnt + 1'b1;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    leds = '0;
    for (int i = 0; i < N_LED; i++) begin
      case (modes[i])
        LED_ON:   leds[i] = 1'b1;
        LED_SLOW: leds[i] = slow_ph;
        LED_FAST: leds[i] = fast_ph;
        default:  leds[i] = 1'b0;
      endcase
    end
  end

  // ---------------- Beeper ----------------
  localparam int ON_CYC    = ms_cycles(CLK_HZ, BEEP_ON_MS);
  localparam int OFF_CYC   = ms_cycles(CLK_HZ, BEEP_OFF_MS);
  localparam int TONE_HALF = CLK_HZ / (2 * BEEP_HZ);
  localparam int DUR_MAX   = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
  localparam int DW = cnt_width(DUR_MAX);
  localparam int TW = cnt_width(TONE_HALF);

  beep_state_t   state, state_nxt;
  logic [DW-1:0] dur;
  logic [TW-1:0] tone_cnt;
  logic          tone_ph;
  logic [3:0]    remaining;
  logic          dur_last;

  assign dur_last = (state == B_ON) ? (dur == DW'(ON_CYC - 1)) : (dur == DW'(OFF_CYC - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      B_IDLE: if (beep_start && beep_count != 4'd0) state_nxt = B_ON;
      B_ON:   if (dur_last) state_nxt = (remaining == 4'd1) ? B_IDLE : B_OFF;
      B_OFF:  if (dur_last) state_nxt = B_ON;
      default: state_nxt = B_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= B_IDLE;
      dur       <= '0;
      tone_cnt  <= '0;
      tone_ph   <= 1'b0;
      remaining <= 4'd0;
    end else begin
      state <= state_nxt;
      // Every state entry restarts the duration and tone timers so each burst opens high.
      if (state_nxt != state) begin
        dur      <= '0;
        tone_cnt <= '0;
        tone_ph  <= 1'b0;
      end else if (state != B_IDLE) begin
        dur <= dur + 1'b1;
        if (tone_cnt == TW'(TONE_HALF - 1)) begin
          tone_cnt <= '0;
          tone_ph  <= ~tone_ph;
        end else begin
          tone_cnt <= tone_cnt + 1'b1;
        end
      end
      if (state == B_IDLE && state_nxt == B_ON) remaining <= beep_count;
      else if (state == B_ON && dur_last)       remaining <= remaining - 4'd1;
    end
  end

  assign beep_busy = (state != B_IDLE);
  assign beep_out  = (state == B_ON) && !tone_ph;

endmodule

// File: tb/tb_board_ui_ctrl.sv
// Directed bench for board_ui_ctrl: LED write table plus hand sequences for debounce and beeper.
module tb_board_ui_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] btn_raw;
  logic [1:0] btn_level, btn_press, btn_release;
  logic       led_we;
  logic [2:0] led_idx;
  logic [1:0] led_mode;
  logic [5:0] leds;
  logic       beep_start;
  logic [3:0] beep_count;
  logic       beep_busy, beep_out;

  int total = 0;
  int bad   = 0;
  int tcyc  = 0;

  always #5 clk = ~clk;

  // Cycles since reset release, used to predict blink phases.
  always @(posedge clk) begin
    if (rst) tcyc <= 0;
    else     tcyc <= tcyc + 1;
  end

  board_ui_ctrl #(
    .CLK_HZ        (10_000),
    .N_LED         (6),
    .N_BTN         (2),
    .DEBOUNCE_MS   (2),
    .BLINK_SLOW_MS (4),
    .BLINK_FAST_MS (1),
    .BEEP_HZ       (1000),
    .BEEP_ON_MS    (3),
    .BEEP_OFF_MS   (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .led_we      (led_we),
    .led_idx     (led_idx),
    .led_mode    (led_mode),
    .leds        (leds),
    .beep_start  (beep_start),
    .beep_count  (beep_count),
    .beep_busy   (beep_busy),
    .beep_out    (beep_out)
  );

  typedef struct {
    logic [2:0]  idx;
    logic [1:0]  mode;
    logic [11:0] exp_modes;  // {led5..led0}, two bits each
  } led_vec_t;

  led_vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] model_leds(input logic [11:0] m, input int t);
    logic [5:0] r;
    logic [1:0] md;
    r = '0;
    for (int i = 0; i < 6; i++) begin
      md = m[2*i +: 2];
      case (md)
        2'd1: r[i] = 1'b1;
        2'd2: r[i] = ((t / 40) % 2) == 1;
        2'd3: r[i] = ((t / 10) % 2) == 1;
        default: r[i] = 1'b0;
      endcase
    end
    return r;
  endfunction

  function automatic logic model_beep(input int t);
    int pos;
    if (t < 0 || t >= 130) return 1'b0;
    pos = t % 50;
    if (pos >= 30) return 1'b0;
    return ((pos / 5) % 2) == 0;
  endfunction

  initial begin
    int presses, releases, hit_at, other, busy_cnt;
    logic lvl_at_hit;
    logic [11:0] cur_modes;

    vecs[0] = '{3'd0, 2'd1, 12'b00_00_00_00_00_01};
    vecs[1] = '{3'd2, 2'd2, 12'b00_00_00_10_00_01};
    vecs[2] = '{3'd3, 2'd3, 12'b00_00_11_10_00_01};
    vecs[3] = '{3'd6, 2'd1, 12'b00_00_11_10_00_01};
    vecs[4] = '{3'd7, 2'd3, 12'b00_00_11_10_00_01};
    vecs[5] = '{3'd5, 2'd1, 12'b01_00_11_10_00_01};
    vecs[6] = '{3'd5, 2'd0, 12'b00_00_11_10_00_01};

    rst = 1'b1; btn_raw = 2'b11; led_we = 1'b0; led_idx = '0; led_mode = '0;
    beep_start = 1'b0; beep_count = '0;
    repeat (3) step();
    check("rst_level", btn_level, 2'b00);
    check("rst_press", btn_press | btn_release, 2'b00);
    check("rst_leds", leds, 6'd0);
    check("rst_busy", beep_busy, 1'b0);
    check("rst_beep", beep_out, 1'b0);
    rst = 1'b0;

    // 1: bouncy press, last edge at c=50
    presses = 0; hit_at = -1; other = 0; lvl_at_hit = 1'b0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (btn_press[0]) begin presses++; hit_at = c; lvl_at_hit = btn_level[0]; end
      if (btn_release[0] || btn_press[1] || btn_release[1] || btn_level[1]) other++;
      if (c < 50 && c % 5 == 0) btn_raw[0] = ~btn_raw[0];
      else if (c == 50)         btn_raw[0] = 1'b0;
    end
    check("press_count", presses, 1);
    check("press_latency", hit_at - 50, 22);
    check("press_level_same_cycle", lvl_at_hit, 1'b1);
    check("level_after_press", btn_level[0], 1'b1);
    check("btn1_quiet_and_no_rel", other, 0);

    // 2: release with a 10-cycle glitch, glitch ends at c=20
    releases = 0; hit_at = -1; other = 0;
    for (int c = 0; c < 80; c++) begin
      step();
      if (btn_release[0]) begin releases++; hit_at = c; end
      if (btn_press[0] || btn_press[1] || btn_release[1]) other++;
      if (c == 0)  btn_raw[0] = 1'b1;
      if (c == 10) btn_raw[0] = 1'b0;
      if (c == 20) btn_raw[0] = 1'b1;
    end
    check("release_count", releases, 1);
    check("release_latency", hit_at - 20, 22);
    check("level_after_release", btn_level[0], 1'b0);
    check("no_spurious_pulses", other, 0);

    // 3: LED write table
    for (int v = 0; v < 7; v++) begin
      led_we = 1'b1; led_idx = vecs[v].idx; led_mode = vecs[v].mode;
      step();
      led_we = 1'b0;
      check($sformatf("led_vec%0d_next", v), leds, model_leds(vecs[v].exp_modes, tcyc));
      for (int k = 0; k < 3; k++) begin
        step();
        check($sformatf("led_vec%0d_hold", v), leds, model_leds(vecs[v].exp_modes, tcyc));
      end
    end
    cur_modes = vecs[6].exp_modes;
    for (int k = 0; k < 90; k++) begin
      step();
      check("led_blink", leds, model_leds(cur_modes, tcyc));
    end

    // 4: three bursts, ignored restart at k=40
    beep_start = 1'b1; beep_count = 4'd3;
    busy_cnt = 0;
    for (int k = 1; k <= 140; k++) begin
      step();
      if (beep_busy) busy_cnt++;
      check($sformatf("beep_busy_k%0d", k), beep_busy, (k >= 1 && k <= 130));
      check($sformatf("beep_out_k%0d", k), beep_out, model_beep(k - 1));
      if (k == 1)  beep_start = 1'b0;
      if (k == 40) begin beep_start = 1'b1; beep_count = 4'd5; end
      if (k == 41) beep_start = 1'b0;
    end
    check("beep_busy_total", busy_cnt, 130);

    // 5: zero-count start is a no-op, then reset mid-burst
    beep_start = 1'b1; beep_count = 4'd0;
    step();
    beep_start = 1'b0;
    busy_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (beep_busy) busy_cnt++;
    end
    check("beep_zero_ignored", busy_cnt, 0);
    beep_start = 1'b1; beep_count = 4'd2;
    step();
    beep_start = 1'b0;
    check("beep_second_start", beep_busy, 1'b1);
    repeat (10) step();
    rst = 1'b1;
    step();
    check("mid_rst_busy", beep_busy, 1'b0);
    check("mid_rst_beep", beep_out, 1'b0);
    check("mid_rst_leds", leds, 6'd0);
    rst = 1'b0;
    other = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (leds != 6'd0 || beep_busy) other++;
    end
    check("modes_cleared_after_rst", other, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
